// File: rtl/udma_tx_lin_arbiter.sv
// Round-robin arbiter for the uDMA TX linear channels onto the single L2 read port,
// with an in-order ID FIFO that steers read responses back. Optional: UDMA_TX_ARB_ERR_EN.
module udma_tx_lin_arbiter #(
    parameter int N_CH    = 6,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH-1:0]          ch_req_i,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
    output logic [N_CH-1:0]          ch_gnt_o,
    output logic [N_CH-1:0]          ch_rvalid_o,
    output logic [DATA_W-1:0]        ch_rdata_o,
    output logic                     mem_req_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic                     mem_gnt_i,
    input  logic                     mem_rvalid_i,
    input  logic [DATA_W-1:0]        mem_rdata_i,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  win;
    logic             win_found;
    logic             any_req;
    logic             full;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CH_W-1:0]  id_fifo [MAX_OUT];

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= N_CH) s = s - N_CH;
        return CH_W'(s);
    endfunction

    // First requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        win       = rr_ptr;
        win_found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!win_found && ch_req_i[wrap_add(rr_ptr, i)]) begin
                win       = wrap_add(rr_ptr, i);
                win_found = 1'b1;
            end
        end
    end

    assign any_req    = |ch_req_i;
    assign full       = (count == FULL_CNT);
    assign mem_req_o  = any_req & ~full;
    assign mem_addr_o = ch_addr_i[int'(win)*ADDR_W +: ADDR_W];
    assign push       = mem_req_o & mem_gnt_i;
    assign pop        = mem_rvalid_i & (count != '0);
    assign busy_o     = (count != '0);

    for (genvar k = 0; k < N_CH; k++) begin : g_gnt
        assign ch_gnt_o[k] = push & (win == CH_W'(k));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr      <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ch_rvalid_o <= '0;
            ch_rdata_o  <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= win;
                wr_ptr          <= wr_ptr + PTR_W'(1);
                rr_ptr          <= (win == LAST_CH) ? '0 : win + CH_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                ch_rdata_o <= mem_rdata_i;
            end
            // Full blocks the request, so push never sees count==MAX_OUT; pop never sees 0.
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            ch_rvalid_o <= pop ? (N_CH'(1) << id_fifo[rd_ptr]) : '0;
        end
    end

`ifdef UDMA_TX_ARB_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_q <= 1'b0;
        else if ((mem_rvalid_i && (count == '0)) || (push && full))
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    a_gnt_onehot:    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ch_gnt_o));
    a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ch_rvalid_o));

endmodule
